slc3_datapath_p: RTL and testbench
==================================

Name: slc3_datapath_p

Overview:
Parametrised successor of the SLC-3 datapath: PC/MAR/MDR/IR, 8-entry register file, ALU, address adder, NZP/BEN logic and one-hot bus driver, generalised to DATA_W bits. Replaces fixed memory wait states with a req/ack handshake FSM and timeout. Sits between the control FSM (which drives gate/ld/sel) and memory or the I/O bridge.

Parameters:
DATA_W, 16, datapath/bus/register width (>=16); immediates sign-extended to DATA_W
RESET_PC, 0, PC value on reset (DATA_W bits)
MEM_TIMEOUT, 15, max cycles in REQ without mem_ack before abort (>=1)

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  asynchronous, active-high; clears all state
gate  in  4  bus drivers {MDR,ALU,PC,MARMUX}
ld  in  7  loads {PC,MDR,MAR,IR,REG,BEN,CC}
sel  in  4  {DRMUX,SR1MUX,SR2MUX,ADDR1MUX}
PCMUX  in  2  PC source
ADDR2MUX  in  2  adder offset source
ALUK  in  2  ALU op
mem_cmd  in  2  00 none, 01 read, 10 write, 11 none
mem_req  out  1  memory request, held until ack/timeout
mem_we  out  1  write qualifier, valid while mem_req
mem_addr  out  DATA_W  address latched from MAR at start
mem_wdata  out  DATA_W  data latched from MDR at start
mem_rdata  in  DATA_W  read data, sampled with mem_ack
mem_ack  in  1  single-cycle completion
mem_busy  out  1  FSM not IDLE
mem_err  out  1  one-cycle pulse on timeout
PC  out  DATA_W  program counter
MAR  out  DATA_W  memory address register
MDR  out  DATA_W  memory data register
IR  out  DATA_W  instruction register
BEN  out  1  branch enable
nzp  out  3  condition codes {N,Z,P}
bus_conflict  out  1  see Optional Feature

Behaviour:
- Reset: PC=RESET_PC; MAR=MDR=IR=0; R0-R7=0; nzp=3'b010; BEN=0; FSM IDLE; mem_req/mem_we/mem_err=0, combinationally on Reset assert (mid-transaction abort, no MDR update).
- Bus: combinational; one gate -> its source; none -> 0; several -> priority MDR>ALU>PC>MARMUX.
- PCMUX: 00 PC+1 (mod 2^DATA_W), 01 adder, 10 bus, 11 hold. ld[PC] required for any change.
- DR: DRMUX 0 IR[11:9], 1 R7. SR1: SR1MUX 0 IR[11:9], 1 IR[8:6]. SR2 = IR[2:0]; SR2MUX 1 selects sext(IR[4:0]).
- ALUK: 00 ADD (carry dropped), 01 AND, 10 NOT SR1, 11 pass SR1. ADDR1MUX: 0 PC, 1 SR1. ADDR2MUX: 00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0].
- ld[MAR]/ld[IR]/ld[REG]/ld[MDR] capture bus next edge; write-then-read of same register in one cycle reads old value.
- ld[CC]: N=bus[DATA_W-1], Z=(bus==0), P=otherwise; exactly one bit set. ld[BEN]: BEN=|(IR[11:9] & nzp), using pre-edge nzp.
- FSM IDLE->REQ on mem_cmd 01/10: latch mem_addr=MAR, mem_wdata=MDR, mem_we=(cmd==10); mem_req=1 from next cycle. mem_cmd ignored outside IDLE.
- REQ: ack -> read: MDR<=mem_rdata (overrides ld[MDR] same edge); write: no reg update; -> IDLE, mem_req drops next cycle. Ack with mem_req low ignored.
- Timeout: MEM_TIMEOUT cycles in REQ without ack -> ERR one cycle (mem_err=1, mem_req=0, MDR unchanged) -> IDLE. MAR/MDR changes during REQ do not alter latched mem_addr/mem_wdata.

Optional Feature:
SLC3_BUS_CONFLICT_DETECT_EN defined: bus_conflict=1 in any cycle with >1 gate bit set, registered sticky until Reset; simulation $error emitted. Undefined: bus_conflict tied 0, no checker logic.

Test Plan:
Reset with Reset high mid-REQ -> mem_req 0 same cycle, PC=RESET_PC, nzp=010, MDR unchanged 0.
R1=0x0005, R2=0xFFFB, ADD R3,R1,R2 with ld[REG|CC] -> R3=0x0000, nzp=010; then BRz IR=0x0403 ld[BEN] -> BEN=1.
Read: MAR=0x3000, mem_cmd=01, ack after 3 cycles with rdata=0xBEEF -> mem_addr=0x3000, MDR=0xBEEF, mem_busy 4 cycles.
Write: MDR=0x1234, cmd=10, MAR changed to 0x0 during REQ -> mem_we=1, mem_addr held 0x3000, mem_wdata 0x1234.
No ack for MEM_TIMEOUT cycles -> mem_err pulse 1 cycle, FSM IDLE, MDR unchanged; new cmd accepted next cycle.
DATA_W=32: PC=0xFFFFFFFF, PCMUX=00 ld[PC] -> PC=0; sext IR[8:0]=0x100 -> adder offset 0xFFFFFF00.

Source files
------------

// File: rtl/slc3_datapath_p_if.sv
// ============================================================================
// Module      : slc3_datapath_p_if
// Description : Control, memory-handshake and observation signals of the
//               parametrised SLC-3 datapath. The control FSM / memory side
//               uses the master modport, the datapath uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface slc3_datapath_p_if #(
  parameter int DATA_W = 16
);
  // Control from the sequencer
  logic [3:0]        gate;      // {MDR,ALU,PC,MARMUX}
  logic [6:0]        ld;        // {PC,MDR,MAR,IR,REG,BEN,CC}
  logic [3:0]        sel;       // {DRMUX,SR1MUX,SR2MUX,ADDR1MUX}
  logic [1:0]        PCMUX;
  logic [1:0]        ADDR2MUX;
  logic [1:0]        ALUK;
  logic [1:0]        mem_cmd;
  // Memory handshake
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_busy;
  logic              mem_err;
  // Architectural state visible to the sequencer
  logic [DATA_W-1:0] PC;
  logic [DATA_W-1:0] MAR;
  logic [DATA_W-1:0] MDR;
  logic [DATA_W-1:0] IR;
  logic              BEN;
  logic [2:0]        nzp;
  logic              bus_conflict;

  modport master (
    output gate, ld, sel, PCMUX, ADDR2MUX, ALUK, mem_cmd, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_busy, mem_err,
           PC, MAR, MDR, IR, BEN, nzp, bus_conflict
  );

  modport slave (
    input  gate, ld, sel, PCMUX, ADDR2MUX, ALUK, mem_cmd, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_busy, mem_err,
           PC, MAR, MDR, IR, BEN, nzp, bus_conflict
  );
endinterface

`default_nettype wire

// File: rtl/slc3_datapath_p.sv
// ============================================================================
// Module      : slc3_datapath_p
// Description : Parametrised SLC-3 datapath (PC/MAR/MDR/IR, 8x DATA_W register
//               file, ALU, address adder, NZP/BEN, prioritised bus) with a
//               req/ack memory handshake FSM and request timeout.
//               Optional: define SLC3_BUS_CONFLICT_DETECT_EN to enable the
//               sticky multiple-gate bus conflict detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slc3_datapath_p #(
  parameter int                 DATA_W      = 16,
  parameter logic [DATA_W-1:0]  RESET_PC    = '0,
  parameter int                 MEM_TIMEOUT = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  slc3_datapath_p_if.slave  dp
);

  localparam int LD_PC  = 6;
  localparam int LD_MDR = 5;
  localparam int LD_MAR = 4;
  localparam int LD_IR  = 3;
  localparam int LD_REG = 2;
  localparam int LD_BEN = 1;
  localparam int LD_CC  = 0;

  localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2
  } mem_state_t;

  logic [DATA_W-1:0] pc, mar, mdr, ir;
  logic              ben;
  logic [2:0]        nzp;
  logic [DATA_W-1:0] regs [8];

  logic [2:0]        dr, sr1;
  logic [DATA_W-1:0] sr1_val, alu_b, alu_out, addr1, addr2, adder, bus_val;
  logic [DATA_W-1:0] sext5, sext6, sext9, sext11;

  mem_state_t        state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              req_r, we_r, err_r;
  logic [DATA_W-1:0] addr_r, wdata_r;
  logic              rd_done;
  logic              unused_ir_bits;

  assign sext5  = {{(DATA_W-5){ir[4]}},   ir[4:0]};
  assign sext6  = {{(DATA_W-6){ir[5]}},   ir[5:0]};
  assign sext9  = {{(DATA_W-9){ir[8]}},   ir[8:0]};
  assign sext11 = {{(DATA_W-11){ir[10]}}, ir[10:0]};
  assign unused_ir_bits = ^ir[DATA_W-1:12];

  assign dr      = dp.sel[3] ? 3'd7 : ir[11:9];
  assign sr1     = dp.sel[2] ? ir[8:6] : ir[11:9];
  assign sr1_val = regs[sr1];
  assign alu_b   = dp.sel[1] ? sext5 : regs[ir[2:0]];
  assign addr1   = dp.sel[0] ? sr1_val : pc;
  assign adder   = addr1 + addr2;

  // ALU, address-offset select and the prioritised one-hot bus
  always_comb begin
    alu_out = sr1_val;
    case (dp.ALUK)
      2'b00:   alu_out = sr1_val + alu_b;
      2'b01:   alu_out = sr1_val & alu_b;
      2'b10:   alu_out = ~sr1_val;
      default: alu_out = sr1_val;
    endcase
    addr2 = '0;
    case (dp.ADDR2MUX)
      2'b01:   addr2 = sext6;
      2'b10:   addr2 = sext9;
      2'b11:   addr2 = sext11;
      default: addr2 = '0;
    endcase
    bus_val = '0;
    if (dp.gate[3])      bus_val = mdr;
    else if (dp.gate[2]) bus_val = alu_out;
    else if (dp.gate[1]) bus_val = pc;
    else if (dp.gate[0]) bus_val = adder;
  end

  // A completed read owns MDR on its ack edge, ahead of any bus load
  assign rd_done = (state == S_REQ) && dp.mem_ack && !we_r;

  // Architectural registers: PC, MAR, MDR, IR, register file, CC and BEN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc  <= RESET_PC;
      mar <= '0;
      mdr <= '0;
      ir  <= '0;
      ben <= 1'b0;
      nzp <= 3'b010;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (dp.ld[LD_PC]) begin
        case (dp.PCMUX)
          2'b00:   pc <= pc + DATA_W'(1);
          2'b01:   pc <= adder;
          2'b10:   pc <= bus_val;
          default: pc <= pc;
        endcase
      end
      if (dp.ld[LD_MAR]) mar <= bus_val;
      if (rd_done)             mdr <= dp.mem_rdata;
      else if (dp.ld[LD_MDR])  mdr <= bus_val;
      if (dp.ld[LD_IR])  ir <= bus_val;
      if (dp.ld[LD_REG]) regs[dr] <= bus_val;
      if (dp.ld[LD_BEN]) ben <= |(ir[11:9] & nzp);
      if (dp.ld[LD_CC]) begin
        if (bus_val[DATA_W-1])   nzp <= 3'b100;
        else if (bus_val == '0)  nzp <= 3'b010;
        else                     nzp <= 3'b001;
      end
    end
  end

  // Memory handshake FSM: latch address/data at start, wait for ack or timeout
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      req_r    <= 1'b0;
      we_r     <= 1'b0;
      err_r    <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          err_r <= 1'b0;
          if (dp.mem_cmd == 2'b01 || dp.mem_cmd == 2'b10) begin
            state    <= S_REQ;
            req_r    <= 1'b1;
            we_r     <= (dp.mem_cmd == 2'b10);
            addr_r   <= mar;
            wdata_r  <= mdr;
            wait_cnt <= '0;
          end
        end
        S_REQ: begin
          if (dp.mem_ack) begin
            state <= S_IDLE;
            req_r <= 1'b0;
            we_r  <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            state <= S_ERR;
            req_r <= 1'b0;
            we_r  <= 1'b0;
            err_r <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_ERR: begin
          state <= S_IDLE;
          err_r <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          req_r <= 1'b0;
          we_r  <= 1'b0;
          err_r <= 1'b0;
        end
      endcase
    end
  end

  assign dp.mem_req   = req_r;
  assign dp.mem_we    = we_r;
  assign dp.mem_err   = err_r;
  assign dp.mem_addr  = addr_r;
  assign dp.mem_wdata = wdata_r;
  assign dp.mem_busy  = (state != S_IDLE);
  assign dp.PC        = pc;
  assign dp.MAR       = mar;
  assign dp.MDR       = mdr;
  assign dp.IR        = ir;
  assign dp.BEN       = ben;
  assign dp.nzp       = nzp;

`ifdef SLC3_BUS_CONFLICT_DETECT_EN
  logic multi_gate;
  logic conflict_seen;

  assign multi_gate = (dp.gate & (dp.gate - 4'd1)) != 4'd0;

  // Sticky record of any cycle where more than one bus driver was enabled
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           conflict_seen <= 1'b0;
    else if (multi_gate) conflict_seen <= 1'b1;
  end

  // Simulation-only warning at the offending edge
  always @(posedge Clk) begin
    if (!Reset && multi_gate) $error("slc3_datapath_p: multiple bus gates %b", dp.gate);
  end

  assign dp.bus_conflict = multi_gate | conflict_seen;
`else
  assign dp.bus_conflict = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slc3_datapath_p.sv
// ============================================================================
// Module      : tb_slc3_datapath_p
// Description : Scoreboard bench for slc3_datapath_p. A spec-level model
//               predicts architectural state and memory transactions; a
//               monitor compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slc3_datapath_p;

  localparam logic [15:0] RPC = 16'h0200;
  localparam int          TO  = 6;

  localparam logic [3:0] G_MDR = 4'b1000, G_ALU = 4'b0100, G_MARMUX = 4'b0001;
  localparam logic [6:0] LD_PC = 7'b1000000, LD_MAR = 7'b0010000,
                         LD_IR = 7'b0001000, LD_REG = 7'b0000100,
                         LD_BEN = 7'b0000010, LD_CC = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  slc3_datapath_p_if #(.DATA_W(16)) dif ();
  slc3_datapath_p_if #(.DATA_W(32)) dif32 ();

  slc3_datapath_p #(.DATA_W(16), .RESET_PC(RPC), .MEM_TIMEOUT(TO)) dut (
    .Clk(clk), .Reset(rst), .dp(dif));
  slc3_datapath_p #(.DATA_W(32), .RESET_PC(32'hFFFF_FFFF), .MEM_TIMEOUT(4)) dut32 (
    .Clk(clk), .Reset(rst), .dp(dif32));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] pc, mar, mdr, ir;
    logic        ben;
    logic [2:0]  nzp;
    logic        req, err, busy;
  } exp_t;
  typedef struct {
    logic [15:0] addr, wdata;
    logic        we;
  } tx_t;

  exp_t exp_q[$];
  tx_t  mem_q[$];

  // Reference model state
  logic [15:0] m_pc, m_mar, m_mdr, m_ir;
  logic [15:0] m_rf [8];
  logic        m_ben, m_we;
  logic [2:0]  m_nzp;
  bit          m_pend, m_err;
  int          m_wait, m_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sext(input logic [15:0] v, input int n);
    int x;
    x = int'(v) % (1 << n);
    if (x >= (1 << (n - 1))) x = x - (1 << n);
    return 16'(x);
  endfunction

  task automatic model_reset();
    m_pc = RPC; m_mar = '0; m_mdr = '0; m_ir = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_ben = 1'b0; m_nzp = 3'b010; m_we = 1'b0;
    m_pend = 0; m_err = 0; m_wait = 0; m_lat = 1;
  endtask

  // One clock of stimulus: drive, predict the post-edge state, advance
  task automatic step(input logic [3:0] g, input logic [6:0] l, input logic [3:0] s,
                      input logic [1:0] pm, input logic [1:0] a2, input logic [1:0] ak,
                      input logic [1:0] cm, input logic ack, input logic [15:0] rd);
    logic [15:0] a, b, alu, off, adder, busv;
    logic [15:0] n_pc, n_mar, n_mdr, n_ir;
    logic [2:0]  n_nzp, dr, sr1;
    logic        n_ben;
    exp_t        e;
    tx_t         t;
    dif.gate = g; dif.ld = l; dif.sel = s; dif.PCMUX = pm; dif.ADDR2MUX = a2;
    dif.ALUK = ak; dif.mem_cmd = cm; dif.mem_ack = ack; dif.mem_rdata = rd;

    sr1 = s[2] ? m_ir[8:6] : m_ir[11:9];
    dr  = s[3] ? 3'd7 : m_ir[11:9];
    a   = m_rf[sr1];
    b   = s[1] ? sext(m_ir, 5) : m_rf[m_ir[2:0]];
    case (ak)
      2'd0: alu = a + b;
      2'd1: alu = a & b;
      2'd2: alu = ~a;
      default: alu = a;
    endcase
    off   = (a2 == 2'd0) ? 16'h0 : (a2 == 2'd1) ? sext(m_ir, 6) :
            (a2 == 2'd2) ? sext(m_ir, 9) : sext(m_ir, 11);
    adder = (s[0] ? a : m_pc) + off;
    busv  = g[3] ? m_mdr : g[2] ? alu : g[1] ? m_pc : g[0] ? adder : 16'h0;

    n_pc = m_pc;
    if (l[6]) n_pc = (pm == 2'd0) ? m_pc + 16'd1 : (pm == 2'd1) ? adder :
                     (pm == 2'd2) ? busv : m_pc;
    n_mdr = l[5] ? busv : m_mdr;
    n_mar = l[4] ? busv : m_mar;
    n_ir  = l[3] ? busv : m_ir;
    n_ben = l[1] ? |(m_ir[11:9] & m_nzp) : m_ben;
    n_nzp = m_nzp;
    if (l[0]) n_nzp = busv[15] ? 3'b100 : (busv == 16'h0) ? 3'b010 : 3'b001;
    if (l[2]) m_rf[dr] = busv;

    if (m_err) begin
      m_err = 0;
    end else if (m_pend) begin
      m_wait++;
      if (ack) begin
        if (!m_we) n_mdr = rd;
        m_pend = 0;
      end else if (m_wait == TO) begin
        m_pend = 0;
        m_err  = 1;
      end
    end else if (cm == 2'b01 || cm == 2'b10) begin
      m_pend = 1; m_we = (cm == 2'b10); m_wait = 0;
      m_lat = $urandom_range(1, TO + 2);
      t.addr = m_mar; t.wdata = m_mdr; t.we = m_we;
      mem_q.push_back(t);
    end

    m_pc = n_pc; m_mar = n_mar; m_mdr = n_mdr; m_ir = n_ir; m_ben = n_ben; m_nzp = n_nzp;
    e.cyc = cyc + 1; e.pc = m_pc; e.mar = m_mar; e.mdr = m_mdr; e.ir = m_ir;
    e.ben = m_ben; e.nzp = m_nzp; e.req = m_pend; e.err = m_err; e.busy = m_pend | m_err;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic [1:0] cm, input logic ack, input logic [15:0] rd);
    step(4'b0, 7'b0, 4'b0, 2'd3, 2'd0, 2'd0, cm, ack, rd);
  endtask

  task automatic load_mdr(input logic [15:0] v);
    idle(2'b01, 1'b0, 16'h0);
    idle(2'b00, 1'b1, v);
  endtask

  task automatic put_ir(input logic [15:0] v);
    load_mdr(v);
    step(G_MDR, LD_IR, 4'b0, 2'd3, 2'd0, 2'd0, 2'b00, 1'b0, 16'h0);
  endtask

  task automatic put_reg(input logic [15:0] irv, input logic [15:0] v);
    put_ir(irv);
    load_mdr(v);
    step(G_MDR, LD_REG, 4'b0, 2'd3, 2'd0, 2'd0, 2'b00, 1'b0, 16'h0);
  endtask

  task automatic step32(input logic [3:0] g, input logic [6:0] l, input logic [1:0] a2,
                        input logic [1:0] cm, input logic ack, input logic [31:0] rd);
    dif32.gate = g; dif32.ld = l; dif32.sel = 4'b0; dif32.PCMUX = 2'd0;
    dif32.ADDR2MUX = a2; dif32.ALUK = 2'd0; dif32.mem_cmd = cm;
    dif32.mem_ack = ack; dif32.mem_rdata = rd;
    @(posedge clk); #1;
  endtask

  // Monitor: architectural state each cycle, memory transactions while mem_req
  exp_t me;
  tx_t  cur;
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        me = exp_q.pop_front();
        chk("PC",       dif.PC,       me.pc);
        chk("MAR",      dif.MAR,      me.mar);
        chk("MDR",      dif.MDR,      me.mdr);
        chk("IR",       dif.IR,       me.ir);
        chk("BEN",      dif.BEN,      me.ben);
        chk("nzp",      dif.nzp,      me.nzp);
        chk("mem_req",  dif.mem_req,  me.req);
        chk("mem_err",  dif.mem_err,  me.err);
        chk("mem_busy", dif.mem_busy, me.busy);
      end
      if (dif.mem_req) begin
        if (!prev_req) begin
          n_checks++;
          if (mem_q.size() == 0) begin
            n_fail++;
            $display("FAIL mem_tx_queued: mem_req raised, got no pending tx expected one");
          end else begin
            cur = mem_q.pop_front();
          end
        end
        chk("mem_addr",  dif.mem_addr,  cur.addr);
        chk("mem_wdata", dif.mem_wdata, cur.wdata);
        chk("mem_we",    dif.mem_we,    cur.we);
      end
    end
    prev_req = dif.mem_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] cm;
    logic       ack;
    dif.gate = '0; dif.ld = '0; dif.sel = '0; dif.PCMUX = '0; dif.ADDR2MUX = '0;
    dif.ALUK = '0; dif.mem_cmd = '0; dif.mem_ack = 1'b0; dif.mem_rdata = '0;
    dif32.gate = '0; dif32.ld = '0; dif32.sel = '0; dif32.PCMUX = '0; dif32.ADDR2MUX = '0;
    dif32.ALUK = '0; dif32.mem_cmd = '0; dif32.mem_ack = 1'b0; dif32.mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_PC", dif.PC, RPC);
    chk("rst_MDR", dif.MDR, 16'h0);
    chk("rst_nzp", dif.nzp, 3'b010);
    chk("rst_BEN", dif.BEN, 1'b0);
    chk("rst_busy", dif.mem_busy, 1'b0);

    // Disturb PC and nzp, start a read, then reset mid-request
    step(4'b0, LD_PC, 4'b0, 2'd0, 2'd0, 2'd0, 2'b00, 1'b0, 16'h0);
    step(4'b0010, LD_CC, 4'b0, 2'd3, 2'd0, 2'd0, 2'b00, 1'b0, 16'h0);
    idle(2'b01, 1'b0, 16'h0);
    idle(2'b00, 1'b0, 16'h0);
    chk("pre_rst_req", dif.mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midreq_rst_req", dif.mem_req, 1'b0);
    chk("midreq_rst_busy", dif.mem_busy, 1'b0);
    chk("midreq_rst_PC", dif.PC, RPC);
    chk("midreq_rst_nzp", dif.nzp, 3'b010);
    chk("midreq_rst_MDR", dif.MDR, 16'h0);
    exp_q.delete();
    mem_q.delete();
    model_reset();
    dif.mem_cmd = 2'b00;
    @(posedge clk); #1 rst = 1'b0;

    // ADD R3,R1,R2 giving zero, then BRz evaluates BEN
    put_reg(16'h0200, 16'h0005);
    put_reg(16'h0400, 16'hFFFB);
    put_ir(16'h1642);
    step(G_ALU, LD_REG | LD_CC, 4'b0100, 2'd3, 2'd0, 2'd0, 2'b00, 1'b0, 16'h0);
    chk("add_zero_nzp", dif.nzp, 3'b010);
    put_ir(16'h0403);
    step(4'b0, LD_BEN, 4'b0, 2'd3, 2'd0, 2'd0, 2'b00, 1'b0, 16'h0);
    chk("brz_BEN", dif.BEN, 1'b1);

    // Read with three-cycle latency
    load_mdr(16'h3000);
    step(G_MDR, LD_MAR, 4'b0, 2'd3, 2'd0, 2'd0, 2'b00, 1'b0, 16'h0);
    idle(2'b01, 1'b0, 16'h0);
    chk("rd_addr", dif.mem_addr, 16'h3000);
    chk("rd_we", dif.mem_we, 1'b0);
    idle(2'b00, 1'b0, 16'h0);
    idle(2'b00, 1'b0, 16'h0);
    idle(2'b00, 1'b1, 16'hBEEF);
    chk("rd_MDR", dif.MDR, 16'hBEEF);
    chk("rd_done_busy", dif.mem_busy, 1'b0);

    // Write: MAR changes during the request, latched address must hold
    load_mdr(16'h1234);
    idle(2'b10, 1'b0, 16'h0);
    step(4'b0, LD_MAR, 4'b0, 2'd3, 2'd0, 2'd0, 2'b00, 1'b0, 16'h0);
    chk("wr_MAR_moved", dif.MAR, 16'h0000);
    chk("wr_we", dif.mem_we, 1'b1);
    chk("wr_addr_held", dif.mem_addr, 16'h3000);
    chk("wr_wdata", dif.mem_wdata, 16'h1234);
    idle(2'b00, 1'b1, 16'hDEAD);
    chk("wr_MDR_kept", dif.MDR, 16'h1234);

    // Stray ack while idle is ignored
    idle(2'b00, 1'b1, 16'hFFFF);
    chk("stray_ack_MDR", dif.MDR, 16'h1234);

    // Timeout
    idle(2'b01, 1'b0, 16'h0);
    repeat (TO - 1) idle(2'b00, 1'b0, 16'h0);
    chk("to_not_yet", dif.mem_err, 1'b0);
    idle(2'b00, 1'b0, 16'h0);
    chk("to_err", dif.mem_err, 1'b1);
    chk("to_req_low", dif.mem_req, 1'b0);
    chk("to_MDR_kept", dif.MDR, 16'h1234);
    idle(2'b01, 1'b0, 16'h0);
    chk("to_err_pulse", dif.mem_err, 1'b0);
    chk("to_idle", dif.mem_busy, 1'b0);
    idle(2'b01, 1'b0, 16'h0);
    chk("to_new_cmd", dif.mem_req, 1'b1);
    idle(2'b00, 1'b1, 16'h5A5A);
    chk("to_new_rd", dif.MDR, 16'h5A5A);

    // Randomised traffic against the model
    repeat (600) begin
      cm  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      ack = m_pend ? (m_wait + 1 == m_lat) : ($urandom_range(0, 7) == 0);
      step(($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom), 7'($urandom), 4'($urandom),
           2'($urandom), 2'($urandom), 2'($urandom), cm, ack, 16'($urandom));
    end
    idle(2'b00, 1'b0, 16'h0);
    #10;
    chk("scoreboard_drained", exp_q.size(), 0);

    // 32-bit instance: PC wrap and 9-bit offset sign extension
    chk("w32_rst_PC", dif32.PC, 32'hFFFF_FFFF);
    step32(4'b0, LD_PC, 2'd0, 2'b00, 1'b0, 32'h0);
    chk("w32_PC_wrap", dif32.PC, 32'h0);
    step32(4'b0, 7'b0, 2'd0, 2'b01, 1'b0, 32'h0);
    step32(4'b0, 7'b0, 2'd0, 2'b00, 1'b1, 32'h0000_0100);
    chk("w32_MDR", dif32.MDR, 32'h0000_0100);
    step32(G_MDR, LD_IR, 2'd0, 2'b00, 1'b0, 32'h0);
    chk("w32_IR", dif32.IR, 32'h0000_0100);
    step32(G_MARMUX, LD_MAR, 2'd2, 2'b00, 1'b0, 32'h0);
    chk("w32_sext9", dif32.MAR, 32'hFFFF_FF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
